piso_serial_tx: RTL and testbench

//  Parallel-in/serial-out frame transmitter that drives a stored word out one bit at a time.
//  It is the outbound counterpart of the flip-flop capture path: a word loads once, then a

---
 rtl/tx_pkg.sv | 19 +
 rtl/bit_timer.sv | 26 ++
 rtl/piso_serial_tx.sv | 129 ++++++++++++
 tb/tb_piso_serial_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared state encoding, idle line level and frame-size helper for the serial frame transmitter.
package tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Bits on the wire per frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int width, input bit parity);
        return width + 2 + (parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while run is high and flags the last cycle of each period.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic run,
    output logic tick
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!clr_n || !run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out frame transmitter (start, data, optional parity, stop) with a true/complement line pair.
// Optional even-parity bit is enabled by defining TX_PARITY_EN.
module piso_serial_tx
    import tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4,
    parameter int LSB_FIRST  = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             ser_out,
    output logic             ser_out_b
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    tx_state_t        state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shift;
    logic [IW-1:0]    bit_idx;
    logic             tick;
`ifdef TX_PARITY_EN
    logic             parity_bit;
`endif

    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
        .clk   (clk),
        .clr_n (clr_n),
        .run   (state != IDLE),
        .tick  (tick)
    );

    // The bit on the wire is always the leading end of the shift register.
    function automatic logic lead_bit(input logic [WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
    endfunction

    always_comb begin
        sreg_shift = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state     <= IDLE;
            sreg      <= '0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ser_out   <= IDLE_LEVEL;
            ser_out_b <= ~IDLE_LEVEL;
`ifdef TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state     <= START;
                        sreg      <= din;
                        bit_idx   <= '0;
                        busy      <= 1'b1;
                        ser_out   <= 1'b0;
                        ser_out_b <= 1'b1;
`ifdef TX_PARITY_EN
                        parity_bit <= ^din;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state     <= DATA;
                        ser_out   <= lead_bit(sreg);
                        ser_out_b <= ~lead_bit(sreg);
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
`ifdef TX_PARITY_EN
                            state     <= PARITY;
                            ser_out   <= parity_bit;
                            ser_out_b <= ~parity_bit;
`else
                            state     <= STOP;
                            ser_out   <= IDLE_LEVEL;
                            ser_out_b <= ~IDLE_LEVEL;
`endif
                        end else begin
                            bit_idx   <= bit_idx + IW'(1);
                            sreg      <= sreg_shift;
                            ser_out   <= lead_bit(sreg_shift);
                            ser_out_b <= ~lead_bit(sreg_shift);
                        end
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state     <= STOP;
                        ser_out   <= IDLE_LEVEL;
                        ser_out_b <= ~IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    ser_out   <= IDLE_LEVEL;
                    ser_out_b <= ~IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: an LSB-first 4-cycle-per-bit instance and an MSB-first 1-cycle-per-bit instance.
`timescale 1ns/1ps
module tb_piso_serial_tx;
    import tx_pkg::*;

`ifdef TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int BC    = 4;
    localparam int NBITS = frame_bits(8, PAR);
    localparam int FRAME = NBITS * BC;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       load = 1'b0;
    logic       load2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] din2 = 8'h00;
    logic       busy, done, ser_out, ser_out_b;
    logic       busy2, done2, ser2, ser2_b;

    int n_checks = 0;
    int n_fail = 0;

    logic ser_log [64];
    logic serb_log[64];
    logic busy_log[64];
    logic done_log[64];

    piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(BC), .LSB_FIRST(1)) dut (
        .clk(clk), .clr_n(clr_n), .load(load), .din(din),
        .busy(busy), .done(done), .ser_out(ser_out), .ser_out_b(ser_out_b)
    );

    piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(1), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .clr_n(clr_n), .load(load2), .din(din2),
        .busy(busy2), .done(done2), .ser_out(ser2), .ser_out_b(ser2_b)
    );

    always #5 clk = ~clk;

    // Expected line level for cycle c of a frame, counting from the cycle after the accepting edge.
    function automatic logic exp_bit(input logic [7:0] d, input int c, input int bc, input bit lsb);
        int b;
        b = c / bc;
        if (b == 0) return 1'b0;
        if (b <= 8) return lsb ? d[b-1] : d[8-b];
        if (PAR && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic record_frame(input bit sel, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            ser_log[start+i]  = sel ? ser2   : ser_out;
            serb_log[start+i] = sel ? ser2_b : ser_out_b;
            busy_log[start+i] = sel ? busy2  : busy;
            done_log[start+i] = sel ? done2  : done;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        @(negedge clk);
        din = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0; din = 8'h00;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ser_out !== 1'b1) begin n_fail++; $display("[TB] FAIL reset ser_out got %b want 1", ser_out); end
        n_checks++; if (ser_out_b !== 1'b0) begin n_fail++; $display("[TB] FAIL reset ser_out_b got %b want 0", ser_out_b); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset done got %b want 0", done); end
        n_checks++; if (ser2 !== 1'b1 || ser2_b !== 1'b0) begin n_fail++; $display("[TB] FAIL reset msb line got %b/%b want 1/0", ser2, ser2_b); end
        n_checks++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset msb busy/done got %b/%b want 0/0", busy2, done2); end
        clr_n = 1'b1;
    endtask

    task automatic test_frame(input logic [7:0] d, input string name);
        logic e;
        applyStimulus(d);
        record_frame(1'b0, 0, FRAME + 2);
        for (int c = 0; c < FRAME; c++) begin
            e = exp_bit(d, c, BC, 1'b1);
            n_checks++; if (ser_log[c] !== e) begin n_fail++; $display("[TB] FAIL %s ser_out c=%0d got %b want %b", name, c, ser_log[c], e); end
            n_checks++; if (serb_log[c] !== ~e) begin n_fail++; $display("[TB] FAIL %s ser_out_b c=%0d got %b want %b", name, c, serb_log[c], ~e); end
            n_checks++; if (busy_log[c] !== 1'b1 || done_log[c] !== 1'b0) begin n_fail++; $display("[TB] FAIL %s busy/done c=%0d got %b/%b want 1/0", name, c, busy_log[c], done_log[c]); end
        end
        n_checks++; if (done_log[FRAME] !== 1'b1 || busy_log[FRAME] !== 1'b0 || ser_log[FRAME] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL %s end done/busy/ser got %b/%b/%b want 1/0/1", name, done_log[FRAME], busy_log[FRAME], ser_log[FRAME]); end
        n_checks++; if (done_log[FRAME+1] !== 1'b0) begin n_fail++; $display("[TB] FAIL %s done width got %b want 0", name, done_log[FRAME+1]); end
    endtask

    task automatic test_basic_frame();
        test_frame(8'hA5, "basic_a5");
    endtask

    task automatic test_parity();
        test_frame(8'h07, "parity_07");
    endtask

    task automatic test_load_while_busy();
        logic e;
        applyStimulus(8'hA5);
        record_frame(1'b0, 0, 14);
        load = 1'b1; din = 8'h3C;
        record_frame(1'b0, 14, 1);
        load = 1'b0;
        record_frame(1'b0, 15, FRAME + 4 - 15);
        for (int c = 0; c < FRAME; c++) begin
            e = exp_bit(8'hA5, c, BC, 1'b1);
            n_checks++; if (ser_log[c] !== e) begin n_fail++; $display("[TB] FAIL busy_load ser_out c=%0d got %b want %b", c, ser_log[c], e); end
        end
        n_checks++; if (done_log[FRAME] !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_load done got %b want 1", done_log[FRAME]); end
        for (int c = FRAME + 1; c < FRAME + 4; c++) begin
            n_checks++; if (busy_log[c] !== 1'b0 || ser_log[c] !== 1'b1) begin
                n_fail++; $display("[TB] FAIL busy_load idle c=%0d busy/ser got %b/%b want 0/1", c, busy_log[c], ser_log[c]); end
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        applyStimulus(8'hC3);
        record_frame(1'b0, 0, FRAME);
        n_checks++; if (done !== 1'b1 || ser_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL b2b gap done/ser/busy got %b/%b/%b want 1/1/0", done, ser_out, busy); end
        load = 1'b1; din = 8'h0F;
        @(negedge clk);
        load = 1'b0; din = 8'h00;
        record_frame(1'b0, 0, FRAME + 1);
        for (int c = 0; c < FRAME; c++) begin
            e = exp_bit(8'h0F, c, BC, 1'b1);
            n_checks++; if (ser_log[c] !== e || busy_log[c] !== 1'b1) begin
                n_fail++; $display("[TB] FAIL b2b frame c=%0d ser/busy got %b/%b want %b/1", c, ser_log[c], busy_log[c], e); end
        end
        n_checks++; if (done_log[FRAME] !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b done got %b want 1", done_log[FRAME]); end
        @(negedge clk);
    endtask

    task automatic test_msb_fast();
        logic e;
        @(negedge clk);
        din2 = 8'h2D; load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0; din2 = 8'h00;
        record_frame(1'b1, 0, NBITS + 2);
        for (int c = 0; c < NBITS; c++) begin
            e = exp_bit(8'h2D, c, 1, 1'b0);
            n_checks++; if (ser_log[c] !== e || serb_log[c] !== ~e) begin
                n_fail++; $display("[TB] FAIL msb ser c=%0d got %b/%b want %b/%b", c, ser_log[c], serb_log[c], e, ~e); end
            n_checks++; if (busy_log[c] !== 1'b1) begin n_fail++; $display("[TB] FAIL msb busy c=%0d got %b want 1", c, busy_log[c]); end
        end
        n_checks++; if (done_log[NBITS] !== 1'b1 || busy_log[NBITS] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL msb end done/busy got %b/%b want 1/0", done_log[NBITS], busy_log[NBITS]); end
        n_checks++; if (done_log[NBITS+1] !== 1'b0) begin n_fail++; $display("[TB] FAIL msb done width got %b want 0", done_log[NBITS+1]); end
    endtask

    task automatic test_reset_mid_frame();
        applyStimulus(8'hA5);
        record_frame(1'b0, 0, 10);
        clr_n = 1'b0; load = 1'b1; din = 8'h3C;
        @(negedge clk);
        n_checks++; if (ser_out !== 1'b1 || ser_out_b !== 1'b0) begin n_fail++; $display("[TB] FAIL abort line got %b/%b want 1/0", ser_out, ser_out_b); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort busy/done got %b/%b want 0/0", busy, done); end
        clr_n = 1'b1; load = 1'b0; din = 8'h00;
        record_frame(1'b0, 0, FRAME + 2);
        for (int c = 0; c < FRAME + 2; c++) begin
            n_checks++; if (busy_log[c] !== 1'b0 || done_log[c] !== 1'b0 || ser_log[c] !== 1'b1) begin
                n_fail++; $display("[TB] FAIL abort quiet c=%0d busy/done/ser got %b/%b/%b want 0/0/1", c, busy_log[c], done_log[c], ser_log[c]); end
        end
        test_frame(8'h81, "after_abort_81");
    endtask

    initial begin
        $display("[TB] piso_serial_tx bench, parity=%0d frame=%0d cycles", PAR, FRAME);
        test_reset();
        test_basic_frame();
        test_parity();
        test_load_while_busy();
        test_back_to_back();
        test_msb_fast();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
